seq_alu: RTL and testbench

- Parametrised, handshaked ALU that generalises the processor's 16-bit combinational ALU to any WIDTH.
- Adds XOR, logical shift-left and an iterative multiply, with a registered result and registered flags.
- Sits between register-read and writeback in the multi-cycle datapath.
- Uses valid/ready handshakes on input and output, so the multiply can stall the pipe.

---
 rtl/seq_alu.sv | 169 ++++++++++++++++
 tb/tb_seq_alu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU with registered result/flags and an iterative
// shift-add multiplier that stalls the input side while it runs.
module seq_alu #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ov,
  output logic             zero,
  output logic             slt,
  output logic             gt,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_AND = 3'b001, OP_OR  = 3'b010,
                         OP_SLT = 3'b011, OP_SUB = 3'b100, OP_XOR = 3'b101,
                         OP_SLL = 3'b110, OP_MUL = 3'b111;

  state_t           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic             slt_p_q, slt_p_d, gt_p_q, gt_p_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d, ov_q, ov_d, zero_q, zero_d;
  logic             slt_q, slt_d, gt_q, gt_d;

  logic             accept, is_sub, is_arith, lt_w, gt_w;
  logic [WIDTH-1:0] b_eff, sum, alu_res, acc_next;
  logic             carry;

  always_comb begin
    in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    is_sub   = (op == OP_SUB);
    is_arith = (op == OP_ADD) || is_sub;
    b_eff    = is_sub ? ~y : y;
    {carry, sum} = {1'b0, x} + {1'b0, b_eff} + (WIDTH+1)'(is_sub ? 1'b1 : cin);
    lt_w     = $signed(x) < $signed(y);
    gt_w     = $signed(x) > $signed(y);
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (op)
      OP_ADD, OP_SUB: alu_res = sum;
      OP_AND:         alu_res = x & y;
      OP_OR:          alu_res = x | y;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, lt_w};
      OP_XOR:         alu_res = x ^ y;
      OP_SLL:         alu_res = x << y[SHW-1:0];
      default:        alu_res = '0;
    endcase

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    slt_p_d     = slt_p_q;
    gt_p_d      = gt_p_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    cout_d      = cout_q;
    ov_d        = ov_q;
    zero_d      = zero_q;
    slt_d       = slt_q;
    gt_d        = gt_q;

    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = (SHW+1)'(WIDTH);
            acc_d    = '0;
            mcand_d  = x;
            mplier_d = y;
            slt_p_d  = lt_w;
            gt_p_d   = gt_w;
          end else begin
            out_valid_d = 1'b1;
            res_d       = alu_res;
            cout_d      = is_arith && carry;
            ov_d        = is_arith && (x[WIDTH-1] == b_eff[WIDTH-1])
                                   && (sum[WIDTH-1] != x[WIDTH-1]);
            zero_d      = (alu_res == '0);
            slt_d       = lt_w;
            gt_d        = gt_w;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - (SHW+1)'(1);
        // Last step publishes the product straight from the adder output.
        if (cnt_q == (SHW+1)'(1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          res_d       = acc_next;
          cout_d      = 1'b0;
          ov_d        = 1'b0;
          zero_d      = (acc_next == '0);
          slt_d       = slt_p_q;
          gt_d        = gt_p_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      slt_p_q     <= 1'b0;
      gt_p_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ov_q        <= 1'b0;
      zero_q      <= 1'b0;
      slt_q       <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      slt_p_q     <= slt_p_d;
      gt_p_q      <= gt_p_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      ov_q        <= ov_d;
      zero_q      <= zero_d;
      slt_q       <= slt_d;
      gt_q        <= gt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign cout      = cout_q;
  assign ov        = ov_q;
  assign zero      = zero_q;
  assign slt       = slt_q;
  assign gt        = gt_q;
  assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for single-cycle ops plus
// hand-written MUL, backpressure, 32-bit shift and reset-abort sequences.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1;
  logic [2:0]  op = 3'b000;
  logic [15:0] x = '0, y = '0, res;
  logic        cout, ov, zero, slt, gt, busy;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32;
  logic [2:0]  op32 = 3'b000;
  logic [31:0] x32 = '0, y32 = '0, res32;
  logic        cout32, ov32, zero32, slt32, gt32, busy32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .cout(cout), .ov(ov), .zero(zero),
    .slt(slt), .gt(gt), .busy(busy)
  );

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .op(op32), .x(x32), .y(y32), .cin(1'b0), .out_valid(out_valid32),
    .out_ready(1'b1), .res(res32), .cout(cout32), .ov(ov32), .zero(zero32),
    .slt(slt32), .gt(gt32), .busy(busy32)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x, y;
    logic        cin;
    logic [15:0] res;
    logic        cout, ov, zero, slt, gt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {out_valid, res, cout, ov, zero, slt, gt}
  function automatic logic [63:0] obs();
    return 64'({out_valid, res, cout, ov, zero, slt, gt});
  endfunction

  initial begin
    vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 1, 0};
    vecs[1]  = '{3'b000, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 0, 1, 0, 0, 1};
    vecs[2]  = '{3'b100, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1, 1, 0, 1, 0};
    vecs[3]  = '{3'b011, 16'hFFFD, 16'h0002, 1'b0, 16'h0001, 0, 0, 0, 1, 0};
    vecs[4]  = '{3'b001, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 0, 0, 0, 1, 0};
    vecs[5]  = '{3'b010, 16'h1200, 16'h0034, 1'b0, 16'h1234, 0, 0, 0, 0, 1};
    vecs[6]  = '{3'b101, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 0, 0, 1, 0, 0};
    vecs[7]  = '{3'b110, 16'h0001, 16'h000F, 1'b0, 16'h8000, 0, 0, 0, 1, 0};
    vecs[8]  = '{3'b110, 16'h0003, 16'h0014, 1'b0, 16'h0030, 0, 0, 0, 1, 0};
    vecs[9]  = '{3'b100, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1, 0, 1, 0, 0};
    vecs[10] = '{3'b100, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 0, 0, 0, 1, 0};
    vecs[11] = '{3'b100, 16'h0003, 16'h0001, 1'b1, 16'h0002, 1, 0, 0, 0, 1};
    vecs[12] = '{3'b011, 16'h0002, 16'hFFFD, 1'b0, 16'h0000, 0, 0, 1, 0, 1};

    // Reset state
    #12;
    check("reset_outputs", 64'({out_valid, res, cout, ov, zero, slt, gt, busy}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops, out_ready held high
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = vecs[i].op; x = vecs[i].x; y = vecs[i].y; cin = vecs[i].cin;
      tick();
      $display("vec %0d op=%b x=%h y=%h cin=%b -> res=%h c=%b v=%b z=%b lt=%b gt=%b",
               i, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].cin, res, cout, ov, zero, slt, gt);
      check($sformatf("vec%0d", i), obs(),
            64'({1'b1, vecs[i].res, vecs[i].cout, vecs[i].ov, vecs[i].zero,
                 vecs[i].slt, vecs[i].gt}));
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // MUL: 16 busy cycles, ADD held on in_valid must wait
    @(negedge clk);
    in_valid = 1'b1; op = 3'b111; x = 16'h0123; y = 16'h0010;
    tick();
    op = 3'b000; x = 16'h0001; y = 16'h0001; cin = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("mul_busy_c%0d", k), 64'({busy, in_ready, out_valid}), 64'b100);
      if (k < 15) tick();
    end
    tick();
    $display("mul 0123*0010 -> res=%h out_valid=%b busy=%b", res, out_valid, busy);
    check("mul_result", obs(), 64'({1'b1, 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    check("mul_busy_done", 64'(busy), 64'd0);
    tick();
    check("add_after_mul", obs(), 64'({1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk);
    in_valid = 1'b0;
    tick();

    // Backpressure: AND held for 5 cycles, queued XOR follows without bubble
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b001; x = 16'hF0F0; y = 16'h0FF0;
    tick();
    op = 3'b101; x = 16'h00FF; y = 16'h0F0F;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_c%0d", k), 64'({out_valid, res, in_ready}),
            64'({1'b1, 16'h00F0, 1'b0}));
      tick();
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    $display("bp release xor -> res=%h out_valid=%b", res, out_valid);
    check("bp_xor_follow", 64'({out_valid, res}), 64'({1'b1, 16'h0FF0}));
    @(negedge clk);
    in_valid = 1'b0;
    tick();

    // 32-bit SLL, including shift amount truncation
    @(negedge clk);
    in_valid32 = 1'b1; op32 = 3'b110; x32 = 32'h0000_0001; y32 = 32'd31;
    tick();
    $display("sll32 1<<31 -> res=%h", res32);
    check("sll32_by31", 64'({out_valid32, res32}), 64'({1'b1, 32'h8000_0000}));
    y32 = 32'h20;
    tick();
    $display("sll32 1<<0x20 -> res=%h", res32);
    check("sll32_wrap", 64'({out_valid32, res32}), 64'({1'b1, 32'h0000_0001}));
    @(negedge clk);
    in_valid32 = 1'b0;
    tick();

    // Reset mid-MUL aborts immediately
    @(negedge clk);
    in_valid = 1'b1; op = 3'b111; x = 16'h0123; y = 16'h0010;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mul", 64'({out_valid, res, cout, ov, zero, slt, gt, busy}), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = 3'b000; x = 16'd2; y = 16'd3; cin = 1'b0;
    tick();
    $display("post-reset add 2+3 -> res=%h out_valid=%b", res, out_valid);
    check("rst_add", obs(), 64'({1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k > 0 && (out_valid !== 1'b0 || busy !== 1'b0)) begin
        check($sformatf("no_stale_c%0d", k), 64'({out_valid, busy}), 64'd0);
      end
    end
    check("no_stale_final", 64'({out_valid, busy, res}), 64'({2'b00, 16'h0005}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
